// File: rtl/logic_axi4_stream_demux_pkg.sv
// Shared types for the AXI4-Stream demultiplexer.
// Holds the routing FSM state encoding.
package logic_axi4_stream_demux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        DROP   = 2'd2
    } state_t;

endpackage

// File: rtl/logic_axi4_stream_demux_output.sv
// One-entry output register for a single Tx port of the demux.
// Loads on the same edge it drains, so a full port streams without bubbles.
module logic_axi4_stream_demux_output #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_tready,
    input  logic [W-1:0] i_data,
    output logic         o_tvalid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end else if (i_tready) begin
            r_valid <= 1'b0;
        end
    end

    // Payload is qualified by r_valid, so it carries no reset.
    always_ff @(posedge i_clk) begin
        if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_tvalid = r_valid;
    assign o_data   = r_data;

endmodule

// File: rtl/logic_axi4_stream_demux.sv
// AXI4-Stream 1-to-N demultiplexer with packet locking on tdest.
// Beats with an out-of-range tdest are discarded and flagged on rx_drop.
module logic_axi4_stream_demux
    import logic_axi4_stream_demux_pkg::*;
#(
    parameter int OUTPUTS     = 4,
    parameter int TDATA_BYTES = 4,
    parameter int TDEST_WIDTH = 2,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1,
    parameter int USE_TLAST   = 1,
    parameter int USE_TKEEP   = 1,
    parameter int USE_TSTRB   = 1
) (
    input  logic                                        aclk,
    input  logic                                        areset_n,
    input  logic                                        rx_tvalid,
    output logic                                        rx_tready,
    input  logic                                        rx_tlast,
    input  logic [TDATA_BYTES-1:0][7:0]                 rx_tdata,
    input  logic [TDATA_BYTES-1:0]                      rx_tstrb,
    input  logic [TDATA_BYTES-1:0]                      rx_tkeep,
    input  logic [TDEST_WIDTH-1:0]                      rx_tdest,
    input  logic [TUSER_WIDTH-1:0]                      rx_tuser,
    input  logic [TID_WIDTH-1:0]                        rx_tid,
    output logic [OUTPUTS-1:0]                          tx_tvalid,
    input  logic [OUTPUTS-1:0]                          tx_tready,
    output logic [OUTPUTS-1:0]                          tx_tlast,
    output logic [OUTPUTS-1:0][TDATA_BYTES-1:0][7:0]    tx_tdata,
    output logic [OUTPUTS-1:0][TDATA_BYTES-1:0]         tx_tstrb,
    output logic [OUTPUTS-1:0][TDATA_BYTES-1:0]         tx_tkeep,
    output logic [OUTPUTS-1:0][TDEST_WIDTH-1:0]         tx_tdest,
    output logic [OUTPUTS-1:0][TUSER_WIDTH-1:0]         tx_tuser,
    output logic [OUTPUTS-1:0][TID_WIDTH-1:0]           tx_tid,
    output logic                                        rx_drop
);

    localparam int SEL_W = $clog2(OUTPUTS);
    localparam int PW    = 1 + 10 * TDATA_BYTES + TDEST_WIDTH
                         + TUSER_WIDTH + TID_WIDTH;
    localparam logic [TDEST_WIDTH:0] NOUT = (TDEST_WIDTH + 1)'(OUTPUTS);

    if (OUTPUTS < 2) begin : g_bad_outputs
        $error("OUTPUTS must be at least 2");
    end
    if (TDEST_WIDTH < SEL_W) begin : g_bad_tdest
        $error("TDEST_WIDTH too narrow to address all OUTPUTS");
    end

    state_t             r_state;
    state_t             w_next;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_sel_next;
    logic [SEL_W-1:0]   w_route;
    logic               w_route_ok;
    logic               w_drop_mode;
    logic               w_dest_ok;
    logic               w_accept;
    logic               w_blocked;
    logic               r_run;
    logic [OUTPUTS-1:0] w_hit;
    logic [OUTPUTS-1:0] w_load;
    logic [PW-1:0]      w_payload;

    assign w_dest_ok = {1'b0, rx_tdest} < NOUT;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_sel   <= w_sel_next;
            r_run   <= 1'b1;
        end
    end

    // Routing decision for the beat currently offered on Rx.
    always_comb begin
        w_route     = r_sel;
        w_route_ok  = 1'b0;
        w_drop_mode = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_route     = rx_tdest[SEL_W-1:0];
                w_route_ok  = w_dest_ok;
                w_drop_mode = !w_dest_ok;
            end
            LOCKED: w_route_ok  = 1'b1;
            DROP:   w_drop_mode = 1'b1;
            default: w_drop_mode = 1'b1;
        endcase
    end

    always_comb begin
        w_hit = '0;
        for (int p = 0; p < OUTPUTS; p++) begin
            w_hit[p] = w_route_ok && (w_route == SEL_W'(p));
        end
    end

    assign w_blocked = |(w_hit & tx_tvalid & ~tx_tready);
    assign rx_tready = r_run && (w_drop_mode || !w_blocked);
    assign w_accept  = rx_tvalid && rx_tready;
    assign rx_drop   = w_accept && w_drop_mode;
    assign w_load    = w_hit & {OUTPUTS{w_accept}};

    always_comb begin
        w_next     = r_state;
        w_sel_next = r_sel;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_dest_ok) begin
                        w_sel_next = rx_tdest[SEL_W-1:0];
                    end
                    if (USE_TLAST != 0 && !rx_tlast) begin
                        w_next = w_dest_ok ? LOCKED : DROP;
                    end
                end
            end
            LOCKED, DROP: begin
                if (w_accept && rx_tlast) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_payload = {rx_tlast, rx_tdata, rx_tstrb, rx_tkeep,
                        rx_tdest, rx_tuser, rx_tid};

    for (genvar p = 0; p < OUTPUTS; p++) begin : g_port
        logic [PW-1:0]          w_out;
        logic [TDATA_BYTES-1:0] w_strb;
        logic [TDATA_BYTES-1:0] w_keep;

        logic_axi4_stream_demux_output #(
            .W(PW)
        ) u_out (
            .i_clk   (aclk),
            .i_rst_n (areset_n),
            .i_load  (w_load[p]),
            .i_tready(tx_tready[p]),
            .i_data  (w_payload),
            .o_tvalid(tx_tvalid[p]),
            .o_data  (w_out)
        );

        assign {tx_tlast[p], tx_tdata[p], w_strb, w_keep,
                tx_tdest[p], tx_tuser[p], tx_tid[p]} = w_out;
        assign tx_tstrb[p] = (USE_TSTRB != 0) ? w_strb : '1;
        assign tx_tkeep[p] = (USE_TKEEP != 0) ? w_keep : '1;
    end

endmodule

// File: tb/tb_logic_axi4_stream_demux.sv
// Scoreboard bench for the AXI4-Stream demux: locked (A) and
// per-beat (B, no tlast, no keep/strb) instances share clock and reset.
module tb_logic_axi4_stream_demux;

    typedef struct {
        logic [45:0] v;
        int          cyc;
        bit          lat;
    } exp_t;

    logic aclk = 1'b0;
    logic areset_n = 1'b0;
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int vec = 0;
    int err = 0;
    exp_t q[2][4][$];

    logic a_rx_tvalid, a_rx_tready, a_rx_tlast, a_rx_drop;
    logic [3:0][7:0] a_rx_tdata;
    logic [3:0] a_rx_tstrb, a_rx_tkeep;
    logic [2:0] a_rx_tdest;
    logic [0:0] a_rx_tuser, a_rx_tid;
    logic [3:0] a_tx_tvalid, a_tx_tready, a_tx_tlast;
    logic [3:0][3:0][7:0] a_tx_tdata;
    logic [3:0][3:0] a_tx_tstrb, a_tx_tkeep;
    logic [3:0][2:0] a_tx_tdest;
    logic [3:0][0:0] a_tx_tuser, a_tx_tid;

    logic b_rx_tvalid, b_rx_tready, b_rx_tlast, b_rx_drop;
    logic [3:0][7:0] b_rx_tdata;
    logic [3:0] b_rx_tstrb, b_rx_tkeep;
    logic [2:0] b_rx_tdest;
    logic [0:0] b_rx_tuser, b_rx_tid;
    logic [3:0] b_tx_tvalid, b_tx_tready, b_tx_tlast;
    logic [3:0][3:0][7:0] b_tx_tdata;
    logic [3:0][3:0] b_tx_tstrb, b_tx_tkeep;
    logic [3:0][2:0] b_tx_tdest;
    logic [3:0][0:0] b_tx_tuser, b_tx_tid;

    logic_axi4_stream_demux #(
        .OUTPUTS(4), .TDATA_BYTES(4), .TDEST_WIDTH(3),
        .TUSER_WIDTH(1), .TID_WIDTH(1), .USE_TLAST(1),
        .USE_TKEEP(1), .USE_TSTRB(1)
    ) u_dut_a (
        .aclk(aclk), .areset_n(areset_n),
        .rx_tvalid(a_rx_tvalid), .rx_tready(a_rx_tready),
        .rx_tlast(a_rx_tlast), .rx_tdata(a_rx_tdata),
        .rx_tstrb(a_rx_tstrb), .rx_tkeep(a_rx_tkeep),
        .rx_tdest(a_rx_tdest), .rx_tuser(a_rx_tuser),
        .rx_tid(a_rx_tid),
        .tx_tvalid(a_tx_tvalid), .tx_tready(a_tx_tready),
        .tx_tlast(a_tx_tlast), .tx_tdata(a_tx_tdata),
        .tx_tstrb(a_tx_tstrb), .tx_tkeep(a_tx_tkeep),
        .tx_tdest(a_tx_tdest), .tx_tuser(a_tx_tuser),
        .tx_tid(a_tx_tid), .rx_drop(a_rx_drop)
    );

    logic_axi4_stream_demux #(
        .OUTPUTS(4), .TDATA_BYTES(4), .TDEST_WIDTH(3),
        .TUSER_WIDTH(1), .TID_WIDTH(1), .USE_TLAST(0),
        .USE_TKEEP(0), .USE_TSTRB(0)
    ) u_dut_b (
        .aclk(aclk), .areset_n(areset_n),
        .rx_tvalid(b_rx_tvalid), .rx_tready(b_rx_tready),
        .rx_tlast(b_rx_tlast), .rx_tdata(b_rx_tdata),
        .rx_tstrb(b_rx_tstrb), .rx_tkeep(b_rx_tkeep),
        .rx_tdest(b_rx_tdest), .rx_tuser(b_rx_tuser),
        .rx_tid(b_rx_tid),
        .tx_tvalid(b_tx_tvalid), .tx_tready(b_tx_tready),
        .tx_tlast(b_tx_tlast), .tx_tdata(b_tx_tdata),
        .tx_tstrb(b_tx_tstrb), .tx_tkeep(b_tx_tkeep),
        .tx_tdest(b_tx_tdest), .tx_tuser(b_tx_tuser),
        .tx_tid(b_tx_tid), .rx_drop(b_rx_drop)
    );

    // Monitor: reset quiescence, and in-order pop on every Tx handshake.
    always @(negedge aclk) begin
        if (!areset_n) begin
            vec++;
            if (a_tx_tvalid !== 4'b0 || b_tx_tvalid !== 4'b0 ||
                a_rx_tready !== 1'b0 || b_rx_tready !== 1'b0 ||
                a_rx_drop !== 1'b0 || b_rx_drop !== 1'b0) begin
                err++;
                $display("FAIL reset_quiet: txv=%b/%b rdy=%b/%b drop=%b/%b, required all 0",
                         a_tx_tvalid, b_tx_tvalid, a_rx_tready,
                         b_rx_tready, a_rx_drop, b_rx_drop);
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 4; p++) begin
                    logic v, r;
                    logic [45:0] act;
                    exp_t e;
                    v = d ? b_tx_tvalid[p] : a_tx_tvalid[p];
                    r = d ? b_tx_tready[p] : a_tx_tready[p];
                    act = d ? {b_tx_tdata[p], b_tx_tstrb[p], b_tx_tkeep[p],
                               b_tx_tlast[p], b_tx_tdest[p], b_tx_tuser[p],
                               b_tx_tid[p]}
                            : {a_tx_tdata[p], a_tx_tstrb[p], a_tx_tkeep[p],
                               a_tx_tlast[p], a_tx_tdest[p], a_tx_tuser[p],
                               a_tx_tid[p]};
                    if (v && r) begin
                        vec++;
                        if (q[d][p].size() == 0) begin
                            err++;
                            $display("FAIL unexpected_beat dut%0d port%0d: got %h, required no beat",
                                     d, p, act);
                        end else begin
                            e = q[d][p].pop_front();
                            if (act !== e.v || (e.lat && cyc != e.cyc)) begin
                                err++;
                                $display("FAIL beat dut%0d port%0d: got %h at cyc %0d, required %h at cyc %0d",
                                         d, p, act, cyc, e.v, e.cyc);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic drive(input bit d, input logic [2:0] dest,
                         input logic [31:0] data, input logic last);
        if (d) begin
            b_rx_tvalid = 1'b1; b_rx_tdest = dest; b_rx_tdata = data;
            b_rx_tkeep = data[3:0]; b_rx_tstrb = ~data[3:0];
            b_rx_tlast = last; b_rx_tuser = data[4]; b_rx_tid = data[5];
        end else begin
            a_rx_tvalid = 1'b1; a_rx_tdest = dest; a_rx_tdata = data;
            a_rx_tkeep = data[3:0]; a_rx_tstrb = ~data[3:0];
            a_rx_tlast = last; a_rx_tuser = data[4]; a_rx_tid = data[5];
        end
    endtask

    // Expects acceptance at the first negedge; port < 0 means a drop.
    task automatic accept(input bit d, input logic [2:0] dest,
                          input logic [31:0] data, input logic last,
                          input int port, input bit lat);
        int n;
        logic rdy, drp;
        logic [3:0] kp, sb;
        exp_t e;
        n = 0;
        @(negedge aclk);
        rdy = d ? b_rx_tready : a_rx_tready;
        while (!rdy && n < 40) begin
            @(negedge aclk);
            n++;
            rdy = d ? b_rx_tready : a_rx_tready;
        end
        drp = d ? b_rx_drop : a_rx_drop;
        vec++;
        if (!rdy || n != 0) begin
            err++;
            $display("FAIL accept dut%0d data %h: waited %0d cycles, required 0",
                     d, data, n);
        end
        vec++;
        if (drp !== (port < 0)) begin
            err++;
            $display("FAIL rx_drop dut%0d data %h: got %b, required %b",
                     d, data, drp, port < 0);
        end
        if (port >= 0) begin
            kp = d ? 4'hf : data[3:0];
            sb = d ? 4'hf : ~data[3:0];
            e.v = {data, sb, kp, last, dest, data[4], data[5]};
            e.cyc = cyc + 1;
            e.lat = lat;
            q[d][port].push_back(e);
        end
        @(posedge aclk);
        #1;
        if (d) b_rx_tvalid = 1'b0;
        else a_rx_tvalid = 1'b0;
    endtask

    task automatic beat(input bit d, input logic [2:0] dest,
                        input logic [31:0] data, input logic last,
                        input int port, input bit lat);
        drive(d, dest, data, last);
        accept(d, dest, data, last, port, lat);
    endtask

    initial begin
        a_rx_tvalid = 0; a_rx_tlast = 0; a_rx_tdata = '0;
        a_rx_tstrb = '0; a_rx_tkeep = '0; a_rx_tdest = '0;
        a_rx_tuser = '0; a_rx_tid = '0; a_tx_tready = 4'hf;
        b_rx_tvalid = 0; b_rx_tlast = 0; b_rx_tdata = '0;
        b_rx_tstrb = '0; b_rx_tkeep = '0; b_rx_tdest = '0;
        b_rx_tuser = '0; b_rx_tid = '0; b_tx_tready = 4'hf;
        repeat (3) @(posedge aclk);
        #1 areset_n = 1'b1;
        repeat (2) @(posedge aclk);
        #1;

        // 3-beat packet to port 2, one-cycle latency each
        beat(0, 3'd2, 32'h1111_0015, 1'b0, 2, 1'b1);
        beat(0, 3'd2, 32'h2222_002a, 1'b0, 2, 1'b1);
        beat(0, 3'd2, 32'h3333_0033, 1'b1, 2, 1'b1);

        // Locked to port 1 despite a mid-packet tdest of 3
        beat(0, 3'd1, 32'h4444_0001, 1'b0, 1, 1'b1);
        beat(0, 3'd3, 32'h5555_0012, 1'b0, 1, 1'b1);
        beat(0, 3'd0, 32'h6666_0024, 1'b1, 1, 1'b1);

        // Out-of-range tdest: whole packet dropped, then back to IDLE
        beat(0, 3'd5, 32'h7777_0007, 1'b0, -1, 1'b0);
        beat(0, 3'd2, 32'h8888_0018, 1'b1, -1, 1'b0);
        beat(0, 3'd1, 32'h9999_0029, 1'b1, 1, 1'b1);

        // Stalled port 0 does not block port 1
        a_tx_tready[0] = 1'b0;
        beat(0, 3'd0, 32'haaaa_003a, 1'b1, 0, 1'b0);
        beat(0, 3'd1, 32'hbbbb_000b, 1'b0, 1, 1'b1);
        beat(0, 3'd1, 32'hcccc_001c, 1'b1, 1, 1'b1);
        drive(0, 3'd0, 32'hdddd_002d, 1'b1);
        repeat (3) begin
            @(negedge aclk);
            vec++;
            if (a_rx_tready !== 1'b0) begin
                err++;
                $display("FAIL stall_ready: rx_tready=%b, required 0",
                         a_rx_tready);
            end
        end
        @(posedge aclk);
        #1 a_tx_tready[0] = 1'b1;
        accept(0, 3'd0, 32'hdddd_002d, 1'b1, 0, 1'b0);

        // Reset mid-packet while locked to port 3
        beat(0, 3'd3, 32'heeee_000e, 1'b0, 3, 1'b1);
        beat(0, 3'd0, 32'hffff_001f, 1'b0, 3, 1'b1);
        areset_n = 1'b0;
        for (int p = 0; p < 4; p++) q[0][p].delete();
        repeat (3) @(posedge aclk);
        #1 areset_n = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        beat(0, 3'd0, 32'h1234_0030, 1'b1, 0, 1'b1);

        // No tlast: each beat routed on its own tdest
        beat(1, 3'd0, 32'h0a0a_0000, 1'b0, 0, 1'b1);
        beat(1, 3'd1, 32'h0b0b_0011, 1'b0, 1, 1'b1);
        beat(1, 3'd2, 32'h0c0c_0022, 1'b0, 2, 1'b1);
        beat(1, 3'd3, 32'h0d0d_0033, 1'b0, 3, 1'b1);
        beat(1, 3'd6, 32'h0e0e_0004, 1'b0, -1, 1'b0);
        beat(1, 3'd2, 32'h0f0f_0015, 1'b0, 2, 1'b1);

        repeat (4) @(negedge aclk);
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 4; p++) begin
                vec++;
                if (q[d][p].size() != 0) begin
                    err++;
                    $display("FAIL drain dut%0d port%0d: %0d beats missing, required 0",
                             d, p, q[d][p].size());
                end
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/logic_axi4_stream_demux.md
LOGIC_AXI4_STREAM_DEMUX -- requirements
Module: logic_axi4_stream_demux

Interface
REQ-001 OUTPUTS, 4, number of Tx ports; >= 2.
REQ-002 TDATA_BYTES, 4, tdata width in bytes.
REQ-003 TDEST_WIDTH, 2, tdest width; must be >= $clog2(OUTPUTS), else elaboration error.
REQ-004 TUSER_WIDTH, 1; TID_WIDTH, 1, sideband widths.
REQ-005 USE_TLAST, 1, enables packet locking; 0 means every beat is routed independently.
REQ-006 USE_TKEEP, 1; USE_TSTRB, 1, when 0 the tx_tkeep/tx_tstrb outputs are driven all-ones.
REQ-007 aclk  in  1  single clock, all logic rising-edge.
REQ-008 areset_n  in  1  asynchronous, active-low reset.
REQ-009 rx_tvalid / rx_tready  in / out  1  Rx handshake.
REQ-010 rx_tlast  in  1  end of packet.
REQ-011 rx_tdata  in  [TDATA_BYTES-1:0][7:0]  payload.
REQ-012 rx_tstrb, rx_tkeep  in  [TDATA_BYTES-1:0]  byte qualifiers.
REQ-013 rx_tdest  in  [TDEST_WIDTH-1:0]  selects the Tx port.
REQ-014 rx_tuser, rx_tid  in  [TUSER_WIDTH-1:0], [TID_WIDTH-1:0]  sideband.
REQ-015 tx_tvalid / tx_tready  out / in  [OUTPUTS-1:0]  per-port handshake.
REQ-016 tx_tlast, tx_tdata, tx_tstrb, tx_tkeep, tx_tdest, tx_tuser, tx_tid  out  [OUTPUTS-1:0] x Rx width  per-port payload.
REQ-017 rx_drop  out  1  one-cycle pulse per discarded beat.

Function
- REQ-018 Transfer occurs when valid && ready on the same rising edge; the payload is forwarded unchanged, including tdest.
- REQ-019 Each Tx port has a one-entry output register; latency from Rx acceptance to tx_tvalid is 1 cycle; throughput is 1 beat/cycle.
- REQ-020 Port p register load condition: (register empty || tx_tready[p]) && Rx beat accepted for p; it clears when tx_tready[p] is high and there is no new load.
- REQ-021 rx_tready = 1 in DROP or for an invalid destination; otherwise rx_tready = !tx_tvalid[sel] || tx_tready[sel].
- REQ-022 rx_tready may depend combinationally on tx_tready; it never depends on rx_tvalid.
- REQ-023 Routing FSM states: IDLE (packet start), LOCKED (sel held), DROP (discarding).
- REQ-024 In IDLE, beat accepted with rx_tdest < OUTPUTS: sel = rx_tdest; the next state is LOCKED if !rx_tlast, else it stays IDLE.
- REQ-025 In IDLE, beat accepted with rx_tdest >= OUTPUTS: the beat is discarded and rx_drop pulses; the next state is DROP if !rx_tlast.
- REQ-026 In LOCKED, beats go to the latched sel regardless of rx_tdest; an accepted beat with rx_tlast returns the FSM to IDLE.
- REQ-027 In DROP, every accepted beat is discarded and rx_drop pulses; an accepted beat with rx_tlast returns the FSM to IDLE.
- REQ-028 With USE_TLAST=0, the FSM stays in IDLE and each beat is routed by its own rx_tdest.
- REQ-029 A stalled port never blocks the other ports' registered data from draining.
- REQ-030 When a port is full and tx_tready is high, a new Rx beat loads on the same edge, giving a bubble-free stream.

Reset
- REQ-031 While areset_n is low: all tx_tvalid = 0, rx_tready = 0, rx_drop = 0, FSM = IDLE, sel = 0.
- REQ-032 Assertion at any time, including mid-packet, discards the register contents and the partial packet; after deassertion the first beat is treated as a packet start.
- REQ-033 Data, tlast, and sideband registers are not reset.

Structure
- REQ-034 Package logic_axi4_stream_demux_pkg holds the FSM state enum (IDLE, LOCKED, DROP).
- REQ-035 Per-port register is sub-module logic_axi4_stream_demux_output, instantiated OUTPUTS times in a generate loop; the top module holds the FSM and rx_tready logic.

Verification
- REQ-036 3-beat packet, tdest=2, all tx_tready=1 -> tx_tvalid[2] high on cycles 1-3 after acceptance; tlast appears on beat 3; other ports stay idle.
- REQ-037 Packet with tdest=1 whose beat 2 carries tdest=3 -> all beats exit on port 1.
- REQ-038 tdest=5 with OUTPUTS=4, 2-beat packet -> rx_tready=1, two rx_drop pulses, no tx_tvalid.
- REQ-039 Port 0 holding a beat with tx_tready[0]=0 while the next packet targets port 1 -> port-1 beats flow; rx_tready drops only for port-0 beats.
- REQ-040 areset_n low mid-packet (LOCKED, sel=3), then a 1-beat packet with tdest=0 -> all tx_tvalid=0 during reset; the new beat exits on port 0.
- REQ-041 USE_TLAST=0, beats with tdest 0,1,2,3 back-to-back -> one beat on each port, 1-cycle latency each.
